// File: rtl/ahb_sram_slave_if.sv
// AHB-Lite signal bundle between the bus matrix (master side) and the SRAM
// responder (slave side). Clock and reset are kept as plain module ports.
interface ahb_sram_slave_if #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
);
  logic                  HSEL;
  logic [ADDR_WIDTH-1:0] HADDR;
  logic [1:0]            HTRANS;
  logic                  HWRITE;
  logic [2:0]            HSIZE;
  logic [DATA_WIDTH-1:0] HWDATA;
  logic                  HREADY;
  logic                  HREADYOUT;
  logic                  HRESP;
  logic [DATA_WIDTH-1:0] HRDATA;

  modport slave (
    input  HSEL, HADDR, HTRANS, HWRITE, HSIZE, HWDATA, HREADY,
    output HREADYOUT, HRESP, HRDATA
  );

  modport master (
    output HSEL, HADDR, HTRANS, HWRITE, HSIZE, HWDATA, HREADY,
    input  HREADYOUT, HRESP, HRDATA
  );
endinterface

// File: rtl/ahb_sram_slave.sv
// AHB-Lite responder for a word-organised on-chip SRAM with byte, halfword and
// word accesses and a two-cycle ERROR response for out-of-range, oversized or
// misaligned transfers.
// Optional feature macro: AHB_SRAM_WAIT_EN. When defined, a WAIT state and a
// 4-bit down-counter insert WAIT_STATES stall cycles into every OKAY transfer.
// When undefined, WAIT_STATES is ignored and every OKAY transfer is zero-wait.
module ahb_sram_slave #(
  parameter int unsigned           ADDR_WIDTH  = 32,
  parameter int unsigned           DATA_WIDTH  = 32,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = '0,
  parameter int unsigned           MEM_DEPTH   = 1024,
  parameter int unsigned           WAIT_STATES = 1
) (
  input  logic            HCLK,
  input  logic            HRESETn,
  ahb_sram_slave_if.slave ahb
);

  localparam int unsigned IDX_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam logic [ADDR_WIDTH:0] MEM_BYTES =
    (ADDR_WIDTH+1)'(64'(MEM_DEPTH) * 64'd4);
`ifdef AHB_SRAM_WAIT_EN
  localparam logic [3:0] WCNT_INIT =
    (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;
`endif

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
`ifdef AHB_SRAM_WAIT_EN
    ST_WAIT = 3'd1,
`endif
    ST_LAST = 3'd2,
    ST_ERR1 = 3'd3,
    ST_ERR2 = 3'd4
  } state_e;

  state_e           state_q, state_d;
  logic             hreadyout_q, hreadyout_d;
  logic             hresp_q, hresp_d;
  logic [IDX_W-1:0] index_q, index_d;
  logic [1:0]       lane_q, lane_d;
  logic [2:0]       size_q, size_d;
  logic             write_q, write_d;
`ifdef AHB_SRAM_WAIT_EN
  logic [3:0]       wcnt_q, wcnt_d;
`endif

  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

  logic [ADDR_WIDTH-1:0] offset;
  logic                  trans_active;
  logic                  accept;
  logic                  in_range;
  logic                  size_ok;
  logic                  aligned;
  logic                  legal;
  logic [3:0]            byte_en;
  logic                  commit;

  assign trans_active = (ahb.HTRANS == 2'b10) || (ahb.HTRANS == 2'b11);
  assign accept       = ahb.HSEL && trans_active && ahb.HREADY;
  assign offset       = ahb.HADDR - BASE_ADDR;
  assign in_range     = (ahb.HADDR >= BASE_ADDR) && ({1'b0, offset} < MEM_BYTES);
  assign size_ok      = (ahb.HSIZE <= 3'd2);
  assign legal        = in_range && size_ok && aligned;

  // Natural alignment of the address-phase transfer for its size.
  always_comb begin
    aligned = 1'b1;
    case (ahb.HSIZE)
      3'd1:    aligned = (ahb.HADDR[0] == 1'b0);
      3'd2:    aligned = (ahb.HADDR[1:0] == 2'b00);
      default: aligned = 1'b1;
    endcase
  end

  // Next-state, captured transfer attributes and next registered outputs.
  always_comb begin
    state_d = state_q;
    index_d = index_q;
    lane_d  = lane_q;
    size_d  = size_q;
    write_d = write_q;
`ifdef AHB_SRAM_WAIT_EN
    wcnt_d  = wcnt_q;
`endif
    unique case (state_q)
      ST_IDLE, ST_LAST, ST_ERR2: begin
        if (accept) begin
          index_d = offset[IDX_W+1:2];
          lane_d  = ahb.HADDR[1:0];
          size_d  = ahb.HSIZE;
          write_d = ahb.HWRITE;
          if (!legal) begin
            state_d = ST_ERR1;
          end else begin
`ifdef AHB_SRAM_WAIT_EN
            if (WAIT_STATES > 0) begin
              state_d = ST_WAIT;
              wcnt_d  = WCNT_INIT;
            end else begin
              state_d = ST_LAST;
            end
`else
            state_d = ST_LAST;
`endif
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
`ifdef AHB_SRAM_WAIT_EN
      ST_WAIT: begin
        if (wcnt_q == 4'd0) begin
          state_d = ST_LAST;
        end else begin
          wcnt_d = wcnt_q - 4'd1;
        end
      end
`endif
      ST_ERR1: state_d = ST_ERR2;
      default: state_d = ST_IDLE;
    endcase

`ifdef AHB_SRAM_WAIT_EN
    hreadyout_d = !((state_d == ST_ERR1) || (state_d == ST_WAIT));
`else
    hreadyout_d = (state_d != ST_ERR1);
`endif
    hresp_d = (state_d == ST_ERR1) || (state_d == ST_ERR2);
  end

  // State and response flops; reset drops any in-flight transfer at once.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q     <= ST_IDLE;
      hreadyout_q <= 1'b1;
      hresp_q     <= 1'b0;
      index_q     <= '0;
      lane_q      <= 2'b00;
      size_q      <= 3'd0;
      write_q     <= 1'b0;
`ifdef AHB_SRAM_WAIT_EN
      wcnt_q      <= 4'd0;
`endif
    end else begin
      state_q     <= state_d;
      hreadyout_q <= hreadyout_d;
      hresp_q     <= hresp_d;
      index_q     <= index_d;
      lane_q      <= lane_d;
      size_q      <= size_d;
      write_q     <= write_d;
`ifdef AHB_SRAM_WAIT_EN
      wcnt_q      <= wcnt_d;
`endif
    end
  end

  // Byte lanes touched by the transfer currently in its data phase.
  always_comb begin
    byte_en = 4'b0000;
    case (size_q)
      3'd0:    byte_en = 4'b0001 << lane_q;
      3'd1:    byte_en = lane_q[1] ? 4'b1100 : 4'b0011;
      3'd2:    byte_en = 4'b1111;
      default: byte_en = 4'b0000;
    endcase
  end

  assign commit = (state_q == ST_LAST) && write_q;

  // Write data lands on the edge that ends the final data cycle; no reset.
  always_ff @(posedge HCLK) begin
    if (commit) begin
      for (int i = 0; i < 4; i++) begin
        if (byte_en[i]) begin
          mem[index_q][8*i +: 8] <= ahb.HWDATA[8*i +: 8];
        end
      end
    end
  end

  assign ahb.HREADYOUT = hreadyout_q;
  assign ahb.HRESP     = hresp_q;
  assign ahb.HRDATA    = ((state_q == ST_LAST) && !write_q) ? mem[index_q] : '0;

endmodule

// File: tb/tb_ahb_sram_slave.sv
// Self-checking bench for ahb_sram_slave: directed vector table, pipelined
// sequences, protocol corner cases and randomized transfers against a
// byte-addressed reference model. Honours AHB_SRAM_WAIT_EN like the design.
module tb_ahb_sram_slave;

  localparam int unsigned AW    = 32;
  localparam int unsigned DW    = 32;
  localparam logic [31:0] BASE  = 32'h2000_0000;
  localparam int unsigned DEPTH = 1024;
  localparam int unsigned WS    = 2;
`ifdef AHB_SRAM_WAIT_EN
  localparam int EXP_W = WS;
`else
  localparam int EXP_W = 0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic other_stall = 1'b0;

  int n_checks = 0;
  int n_pass   = 0;
  int run_iters;

  ahb_sram_slave_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) ahb_bus ();

  assign ahb_bus.HREADY = ahb_bus.HREADYOUT & ~other_stall;

  ahb_sram_slave #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .BASE_ADDR  (BASE),
    .MEM_DEPTH  (DEPTH),
    .WAIT_STATES(WS)
  ) dut (
    .HCLK   (clk),
    .HRESETn(rst_n),
    .ahb    (ahb_bus.slave)
  );

  // Free-running bus clock, 10 time units per period.
  always #5 clk = ~clk;

  // Hard stop in case a bounded wait is ever missed.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  // Transfer list for apply_stimulus and the per-transfer observations.
  logic        t_wr    [8];
  logic [31:0] t_addr  [8];
  logic [2:0]  t_size  [8];
  logic [31:0] t_wdata [8];
  int          r_cyc   [8];
  logic        r_rdy0  [8];
  logic        r_resp0 [8];
  logic        r_respn [8];
  logic [31:0] r_rdata [8];

  // Reference model memory (word array, updated byte by byte).
  logic [31:0] mdl [DEPTH];

  typedef struct {
    logic        wr;
    logic [31:0] off;
    logic [2:0]  size;
    logic [31:0] wdata;
    logic        err;
    logic [31:0] rd;
  } vec_t;

  vec_t vecs [18];

  function automatic void check_value(input string name, input logic [31:0] act,
                                      input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
  endfunction

  function automatic void fail_now(input string name);
    n_checks++;
    $display("[TB] FAIL %s: bounded wait expired", name);
  endfunction

  function automatic bit mdl_legal(input logic [31:0] addr, input logic [2:0] size);
    longint off;
    off = longint'({32'h0, addr}) - longint'({32'h0, BASE});
    if (off < 0 || off >= longint'(4 * DEPTH)) return 1'b0;
    if (size > 3'd2) return 1'b0;
    return (off % (longint'(1) << size)) == 0;
  endfunction

  function automatic void mdl_write(input logic [31:0] addr, input logic [2:0] size,
                                    input logic [31:0] data);
    longint off;
    longint ba;
    int     w;
    int     ln;
    off = longint'({32'h0, addr}) - longint'({32'h0, BASE});
    for (int b = 0; b < (1 << size); b++) begin
      ba = off + b;
      w  = int'(ba / 4);
      ln = int'(ba % 4);
      mdl[w][8*ln +: 8] = data[8*ln +: 8];
    end
  endfunction

  function automatic logic [31:0] mdl_read(input logic [31:0] addr);
    longint off;
    off = longint'({32'h0, addr}) - longint'({32'h0, BASE});
    return mdl[int'(off / 4)];
  endfunction

  task automatic drive_addr(input int i, input int n);
    if (i < n) begin
      ahb_bus.HSEL   = 1'b1;
      ahb_bus.HTRANS = (i > 0 && t_wr[i] == t_wr[i-1] && t_addr[i] == t_addr[i-1] + 32'd4)
                       ? 2'b11 : 2'b10;
      ahb_bus.HADDR  = t_addr[i];
      ahb_bus.HWRITE = t_wr[i];
      ahb_bus.HSIZE  = t_size[i];
    end else begin
      ahb_bus.HSEL   = 1'b0;
      ahb_bus.HTRANS = 2'b00;
    end
  endtask

  // Runs n pipelined transfers from the t_* lists, recording each data phase.
  task automatic apply_stimulus(input int n);
    int   a;
    int   d;
    int   guard;
    logic rdy;
    logic resp;
    a = 0;
    d = -1;
    guard = 0;
    for (int k = 0; k < n; k++) begin
      r_cyc[k]   = 0;
      r_rdy0[k]  = 1'bx;
      r_resp0[k] = 1'bx;
      r_respn[k] = 1'bx;
      r_rdata[k] = 32'hx;
    end
    @(negedge clk);
    drive_addr(0, n);
    while ((a < n || d >= 0) && guard < 200) begin
      rdy  = ahb_bus.HREADY;
      resp = ahb_bus.HRESP;
      if (d >= 0) begin
        if (r_cyc[d] == 0) begin
          r_rdy0[d]  = rdy;
          r_resp0[d] = resp;
        end
        r_cyc[d]++;
        if (rdy) begin
          r_respn[d] = resp;
          r_rdata[d] = ahb_bus.HRDATA;
        end
      end
      @(posedge clk);
      #1;
      if (rdy) begin
        d = (a < n) ? a : -1;
        if (a < n) a++;
        drive_addr(a, n);
        if (d >= 0) ahb_bus.HWDATA = t_wdata[d];
      end
      @(negedge clk);
      guard++;
    end
    run_iters = guard;
    if (guard >= 200) fail_now("apply_stimulus");
    ahb_bus.HSEL   = 1'b0;
    ahb_bus.HTRANS = 2'b00;
  endtask

  // Compares one recorded transfer against its expected response.
  task automatic check_output(input int k, input string tag, input logic exp_err,
                              input logic [31:0] exp_rd);
    check_value({tag, ".cycles"}, 32'(r_cyc[k]), exp_err ? 32'd2 : 32'(EXP_W + 1));
    check_value({tag, ".resp_first"}, 32'(r_resp0[k]), 32'(exp_err));
    check_value({tag, ".ready_first"}, 32'(r_rdy0[k]),
                exp_err ? 32'd0 : 32'(EXP_W == 0));
    check_value({tag, ".resp_last"}, 32'(r_respn[k]), 32'(exp_err));
    check_value({tag, ".rdata"}, r_rdata[k], (!t_wr[k] && !exp_err) ? exp_rd : 32'h0);
  endtask

  task automatic single(input logic wr, input logic [31:0] addr, input logic [2:0] size,
                        input logic [31:0] wdata);
    t_wr[0]    = wr;
    t_addr[0]  = addr;
    t_size[0]  = size;
    t_wdata[0] = wdata;
    apply_stimulus(1);
  endtask

  initial begin
    logic [31:0] addr;
    logic [2:0]  size;
    logic [31:0] data;
    logic        wr;
    logic        ok;
    int          kind;

    vecs[0]  = '{1'b1, 32'h0000_0010, 3'd2, 32'hDEADBEEF, 1'b0, 32'h0};
    vecs[1]  = '{1'b0, 32'h0000_0010, 3'd2, 32'h5A5A5A5A, 1'b0, 32'hDEADBEEF};
    vecs[2]  = '{1'b1, 32'h0000_0020, 3'd2, 32'h11223344, 1'b0, 32'h0};
    vecs[3]  = '{1'b1, 32'h0000_0021, 3'd0, 32'h0000AA00, 1'b0, 32'h0};
    vecs[4]  = '{1'b0, 32'h0000_0020, 3'd2, 32'h0,        1'b0, 32'h1122AA44};
    vecs[5]  = '{1'b0, 32'h0000_1000, 3'd2, 32'h0,        1'b1, 32'h0};
    vecs[6]  = '{1'b0, 32'h0000_0002, 3'd2, 32'h0,        1'b1, 32'h0};
    vecs[7]  = '{1'b1, 32'h0000_0012, 3'd2, 32'hFFFFFFFF, 1'b1, 32'h0};
    vecs[8]  = '{1'b1, 32'h0000_0011, 3'd1, 32'hFFFFFFFF, 1'b1, 32'h0};
    vecs[9]  = '{1'b1, 32'h0000_0010, 3'd3, 32'hFFFFFFFF, 1'b1, 32'h0};
    vecs[10] = '{1'b1, 32'hFFFF_FFFC, 3'd2, 32'hFFFFFFFF, 1'b1, 32'h0};
    vecs[11] = '{1'b0, 32'h0000_0010, 3'd2, 32'h0,        1'b0, 32'hDEADBEEF};
    vecs[12] = '{1'b1, 32'h0000_0022, 3'd1, 32'hBEEF0000, 1'b0, 32'h0};
    vecs[13] = '{1'b0, 32'h0000_0020, 3'd2, 32'h0,        1'b0, 32'hBEEFAA44};
    vecs[14] = '{1'b1, 32'h0000_0FFC, 3'd2, 32'hCAFEF00D, 1'b0, 32'h0};
    vecs[15] = '{1'b0, 32'h0000_0FFC, 3'd2, 32'h0,        1'b0, 32'hCAFEF00D};
    vecs[16] = '{1'b0, 32'h0000_0FFD, 3'd0, 32'h0,        1'b0, 32'hCAFEF00D};
    vecs[17] = '{1'b0, 32'h0000_0FFE, 3'd1, 32'h0,        1'b0, 32'hCAFEF00D};

    ahb_bus.HSEL   = 1'b0;
    ahb_bus.HTRANS = 2'b00;
    ahb_bus.HADDR  = BASE;
    ahb_bus.HWRITE = 1'b0;
    ahb_bus.HSIZE  = 3'd2;
    ahb_bus.HWDATA = 32'h0;

    $display("[TB] reset values");
    repeat (3) @(negedge clk);
    check_value("reset.hreadyout", 32'(ahb_bus.HREADYOUT), 32'd1);
    check_value("reset.hresp", 32'(ahb_bus.HRESP), 32'd0);
    check_value("reset.hrdata", ahb_bus.HRDATA, 32'h0);
    rst_n = 1'b1;

    $display("[TB] directed vector table");
    for (int i = 0; i < 18; i++) begin
      single(vecs[i].wr, BASE + vecs[i].off, vecs[i].size, vecs[i].wdata);
      check_output(0, $sformatf("vec%0d", i), vecs[i].err, vecs[i].rd);
    end

    $display("[TB] pipelined word burst");
    for (int k = 0; k < 4; k++) begin
      t_wr[k]    = 1'b1;
      t_addr[k]  = BASE + 32'h40 + 32'(4 * k);
      t_size[k]  = 3'd2;
      t_wdata[k] = $urandom;
      mdl[16 + k] = t_wdata[k];
    end
    apply_stimulus(4);
    check_value("burst_wr.iters", 32'(run_iters), 32'(1 + 4 * (EXP_W + 1)));
    for (int k = 0; k < 4; k++) check_output(k, $sformatf("burst_wr%0d", k), 1'b0, 32'h0);
    for (int k = 0; k < 4; k++) begin
      t_wr[k]    = 1'b0;
      t_wdata[k] = $urandom;
    end
    apply_stimulus(4);
    check_value("burst_rd.iters", 32'(run_iters), 32'(1 + 4 * (EXP_W + 1)));
    for (int k = 0; k < 4; k++)
      check_output(k, $sformatf("burst_rd%0d", k), 1'b0, mdl[16 + k]);

    $display("[TB] back-to-back write then read of one word");
    data = $urandom;
    t_wr[0] = 1'b1; t_addr[0] = BASE + 32'h30; t_size[0] = 3'd2; t_wdata[0] = data;
    t_wr[1] = 1'b0; t_addr[1] = BASE + 32'h30; t_size[1] = 3'd2; t_wdata[1] = ~data;
    apply_stimulus(2);
    check_output(0, "raw.wr", 1'b0, 32'h0);
    check_output(1, "raw.rd", 1'b0, data);

    $display("[TB] unselected, busy and stalled-bus cycles");
    @(negedge clk);
    ahb_bus.HSEL = 1'b0; ahb_bus.HTRANS = 2'b10; ahb_bus.HWRITE = 1'b1;
    ahb_bus.HADDR = BASE + 32'h10; ahb_bus.HSIZE = 3'd2; ahb_bus.HWDATA = 32'h0;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      check_value($sformatf("nosel.hreadyout%0d", c), 32'(ahb_bus.HREADYOUT), 32'd1);
    end
    ahb_bus.HSEL = 1'b1; ahb_bus.HTRANS = 2'b01;
    @(negedge clk);
    ahb_bus.HSEL = 1'b0; ahb_bus.HTRANS = 2'b00;
    check_value("busy.hreadyout", 32'(ahb_bus.HREADYOUT), 32'd1);
    check_value("busy.hresp", 32'(ahb_bus.HRESP), 32'd0);
    other_stall = 1'b1;
    ahb_bus.HSEL = 1'b1; ahb_bus.HTRANS = 2'b10;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      check_value($sformatf("stall.hreadyout%0d", c), 32'(ahb_bus.HREADYOUT), 32'd1);
    end
    ahb_bus.HSEL = 1'b0; ahb_bus.HTRANS = 2'b00;
    @(negedge clk);
    other_stall = 1'b0;
    single(1'b0, BASE + 32'h10, 3'd2, 32'h0);
    check_output(0, "untouched", 1'b0, 32'hDEADBEEF);

    $display("[TB] reset during a write data phase");
    single(1'b1, BASE + 32'h80, 3'd2, 32'h0000_0005);
    check_output(0, "rst.prewrite", 1'b0, 32'h0);
    @(negedge clk);
    ahb_bus.HSEL = 1'b1; ahb_bus.HTRANS = 2'b10; ahb_bus.HWRITE = 1'b1;
    ahb_bus.HADDR = BASE + 32'h80; ahb_bus.HSIZE = 3'd2;
    @(posedge clk);
    #1;
    ahb_bus.HSEL = 1'b0; ahb_bus.HTRANS = 2'b00; ahb_bus.HWDATA = 32'h0000_0077;
    @(negedge clk);
    check_value("rst.in_phase_ready", 32'(ahb_bus.HREADYOUT), 32'(EXP_W == 0));
    rst_n = 1'b0;
    #1;
    check_value("rst.hreadyout", 32'(ahb_bus.HREADYOUT), 32'd1);
    check_value("rst.hresp", 32'(ahb_bus.HRESP), 32'd0);
    check_value("rst.hrdata", ahb_bus.HRDATA, 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    single(1'b0, BASE + 32'h80, 3'd2, 32'h0);
    check_output(0, "rst.readback", 1'b0, 32'h0000_0005);

    $display("[TB] randomized transfers against reference model");
    for (int w = 0; w < 16; w++) begin
      data = $urandom;
      addr = BASE + 32'h400 + 32'(4 * w);
      mdl_write(addr, 3'd2, data);
      single(1'b1, addr, 3'd2, data);
      check_output(0, $sformatf("rinit%0d", w), 1'b0, 32'h0);
    end
    for (int i = 0; i < 60; i++) begin
      kind = $urandom_range(0, 9);
      if (kind == 0)      addr = BASE + 32'(4 * DEPTH) + 32'($urandom_range(0, 15));
      else if (kind == 1) addr = BASE - 32'd1 - 32'($urandom_range(0, 15));
      else                addr = BASE + 32'h400 + 32'($urandom_range(0, 63));
      size = 3'($urandom_range(0, 3));
      wr   = 1'($urandom_range(0, 1));
      data = $urandom;
      ok   = mdl_legal(addr, size);
      single(wr, addr, size, data);
      check_output(0, $sformatf("rand%0d", i), !ok, ok ? mdl_read(addr) : 32'h0);
      if (ok && wr) mdl_write(addr, size, data);
    end
    for (int w = 0; w < 16; w++) begin
      addr = BASE + 32'h400 + 32'(4 * w);
      single(1'b0, addr, 3'd2, 32'h0);
      check_output(0, $sformatf("rfinal%0d", w), 1'b0, mdl_read(addr));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
